// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
//   DEF_DW / DEF_VW : default dividend/quotient and divisor/remainder widths
//   DEF_CW          : iteration counter width for the default DW
//   state_t         : divider FSM state encoding (also exposed on dbg_state)
package divider_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_VW = 8;
    localparam int DEF_CW = $clog2(DEF_DW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   p_in    : current partial remainder (always < divisor, so VW bits suffice)
//   bit_in  : next dividend bit, MSB first
//   divisor : captured divisor
//   p_out   : new partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_step
    import divider_pkg::*;
#(
    parameter int VW = DEF_VW
) (
    input  logic [VW-1:0] p_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] p_out,
    output logic          q_bit
);

    // Shifted partial remainder P' needs VW+1 bits for the compare.
    logic [VW:0] p_sh;

    always_comb begin
        p_sh  = {p_in, bit_in};
        q_bit = (p_sh >= {1'b0, divisor});
        // When P' >= divisor the true difference is < divisor < 2^VW, so a
        // VW-bit modular subtraction yields the exact result.
        p_out = q_bit ? (p_sh[VW-1:0] - divisor) : p_sh[VW-1:0];
    end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned divider: DW-bit dividend / VW-bit divisor, one
// quotient bit per clock (radix-2 restoring).
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, accepted on a rising edge when busy=0
//   dividend, divisor   : operands, captured on the accepting edge
//   busy                : operation in progress
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next done
//   div_by_zero         : divisor was 0 (quotient all ones, remainder = dividend LSBs)
//   dbg_state           : current FSM state
//
// Handshake: an operation is accepted on any rising edge where start=1 and
// busy=0; start while busy=1 is ignored. Completion is signalled by a single
// done cycle, during which busy=0, so a new start in that cycle is accepted.
module sequential_divider
    import divider_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(DW + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    // Dividend bits shift out of the MSB while quotient bits shift into the
    // LSB; after DW steps the register holds the complete quotient.
    logic [DW-1:0] dvd_sh;
    logic [VW-1:0] dvs;
    logic [VW-1:0] p;
    logic [VW-1:0] p_next;
    logic          q_bit;

    assign dbg_state = state;

    div_step #(
        .VW(VW)
    ) u_step (
        .p_in   (p),
        .bit_in (dvd_sh[DW-1]),
        .divisor(dvs),
        .p_out  (p_next),
        .q_bit  (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd_sh      <= '0;
            dvs         <= '0;
            p           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sh <= dividend;
                        dvs    <= divisor;
                        p      <= '0;
                        busy   <= 1'b1;
                        if (divisor == '0) begin
                            state <= FINISH;
                        end else begin
                            state <= RUN;
                            cnt   <= CW'(DW);
                        end
                    end
                end
                RUN: begin
                    p      <= p_next;
                    dvd_sh <= {dvd_sh[DW-2:0], q_bit};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quotient    <= {dvd_sh[DW-2:0], q_bit};
                        remainder   <= p_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                FINISH: begin
                    // dvd_sh is untouched here, so it still holds the dividend.
                    quotient    <= '1;
                    remainder   <= dvd_sh[VW-1:0];
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider.sv
module tb_sequential_divider;
    import divider_pkg::*;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int RW = DW + VW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard: {div_by_zero, quotient, remainder} and the matching operands.
    logic [RW-1:0]      exp_q[$];
    logic [DW+VW-1:0]   op_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sequential_divider #(
        .DW(DW),
        .VW(VW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .dbg_state  (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [RW-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        if (b == '0) return {1'b1, {DW{1'b1}}, a[VW-1:0]};
        return {1'b0, DW'(a / b), VW'(a % b)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          prev_done;
    logic [RW-1:0] held;
    logic [RW-1:0] sb_exp;
    logic [DW+VW-1:0] sb_op;
    logic [RW-1:0] obs;

    always @(negedge clk) begin
        obs = {div_by_zero, quotient, remainder};
        if (!rst_n) begin
            prev_done = 1'b0;
            held      = '0;
        end else begin
            if (done) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high on two consecutive cycles");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: got %h with empty queue", obs);
                end else begin
                    sb_exp = exp_q.pop_front();
                    sb_op  = op_q.pop_front();
                    if (obs !== sb_exp) begin
                        errors++;
                        $display("FAIL sb_result: got %h expected %h (op %0d/%0d)",
                                 obs, sb_exp, sb_op[DW+VW-1:VW], sb_op[VW-1:0]);
                    end
                    if (sb_op[VW-1:0] != '0) begin
                        checks++;
                        if ((32'(quotient) * 32'(sb_op[VW-1:0]) + 32'(remainder) != 32'(sb_op[DW+VW-1:VW]))
                            || (remainder >= sb_op[VW-1:0])) begin
                            errors++;
                            $display("FAIL invariant: q=%0d r=%0d for %0d/%0d",
                                     quotient, remainder, sb_op[DW+VW-1:VW], sb_op[VW-1:0]);
                        end
                    end
                end
                held = obs;
            end else begin
                checks++;
                if (obs !== held) begin
                    errors++;
                    $display("FAIL hold: outputs %h changed without done, expected %h", obs, held);
                end
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        op_q.push_back({a, b});
    endtask

    // Waits for done; lat = edges after the accepting edge, busy_n = busy samples.
    task automatic wait_done(output int lat, output int busy_n);
        int cyc;
        bit got;
        cyc    = 0;
        got    = 1'b0;
        lat    = -1;
        busy_n = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            cyc++;
            if (done) begin
                got = 1'b1;
                lat = cyc - 1;
            end else if (busy) begin
                busy_n++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_done_timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int lat, busy_n, exp_lat;
        exp_lat = (b == '0) ? 1 : DW;
        issue(a, b);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency %0d/%0d: got %0d expected %0d", a, b, lat, exp_lat);
        end
        checks++;
        if (busy_n !== exp_lat) begin
            errors++;
            $display("FAIL busy_cycles %0d/%0d: got %0d expected %0d", a, b, busy_n, exp_lat);
        end
        checks++;
        if ({div_by_zero, quotient, remainder} !== model(a, b)) begin
            errors++;
            $display("FAIL result %0d/%0d: got dz=%0b q=%0d r=%0d expected %h",
                     a, b, div_by_zero, quotient, remainder, model(a, b));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b q=%h r=%h dz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(16'd150, 8'd10);
        checks++;
        if (quotient !== 16'd15 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL basic_150_10: got q=%0d r=%0d expected q=15 r=0", quotient, remainder);
        end
    endtask

    task automatic test_values();
        run_op(16'd1000, 8'd7);
        checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6) begin
            errors++;
            $display("FAIL values_1000_7: got q=%0d r=%0d expected q=142 r=6", quotient, remainder);
        end
        run_op(16'd65535, 8'd1);
        run_op(16'd65535, 8'd255);
        checks++;
        if (quotient !== 16'd257 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL values_65535_255: got q=%0d r=%0d expected q=257 r=0", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        run_op(16'h04D2, 8'd0);
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'hD2 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got q=%h r=%h dz=%0b expected q=ffff r=d2 dz=1",
                     quotient, remainder, div_by_zero);
        end
        run_op(16'd100, 8'd3);
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: got dz=%0b expected 0", div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, lat, busy_n;
        bit got;
        issue(16'd150, 8'd10);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) start = 1'b0;
            cyc++;
            if (done) begin
                got = 1'b1;
            end else if (cyc == 5) begin
                // Ignored request while busy; not on the scoreboard.
                start    = 1'b1;
                dividend = 16'd200;
                divisor  = 8'd3;
            end else if (cyc == 6) begin
                start    = 1'b0;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
        end
        checks++;
        if (!got || cyc - 1 !== DW) begin
            errors++;
            $display("FAIL ignore_latency: got done=%0b after %0d edges expected %0d", got, cyc - 1, DW);
        end
        checks++;
        if (quotient !== 16'd15 || remainder !== 8'd0) begin
            errors++;
            $display("FAIL ignore_result: got q=%0d r=%0d expected q=15 r=0", quotient, remainder);
        end
        // Re-request in the done cycle.
        issue(16'd200, 8'd3);
        wait_done(lat, busy_n);
        checks++;
        if (lat !== DW) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected %0d", lat, DW);
        end
        checks++;
        if (quotient !== 16'd66 || remainder !== 8'd2) begin
            errors++;
            $display("FAIL b2b_result: got q=%0d r=%0d expected q=66 r=2", quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        int dn;
        start    = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_busy: got %0b expected 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL abort_async_clear: busy=%0b done=%0b q=%h r=%h dz=%0b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL abort_state: got %0d expected 0", dbg_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", dn);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        for (int i = 0; i < 1000; i++) begin
            a = DW'($urandom_range(0, 65535));
            b = (i % 40 == 7) ? 8'd0 : VW'($urandom_range(1, 255));
            run_op(a, b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected results never produced", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
